// File: rtl/masura_perioada_pkg.sv
// Constants shared by the digital clock design: meter FSM encoding and divider ratios.
package masura_perioada_pkg;

    typedef enum logic {
        ASTEAPTA = 1'b0,
        MASOARA  = 1'b1
    } stare_t;

    localparam int unsigned FRECVENTA_CLK_HZ  = 50_000_000;
    localparam int unsigned RAPORT_1HZ        = FRECVENTA_CLK_HZ;
    localparam int unsigned RAPORT_MUX_AFISAJ = FRECVENTA_CLK_HZ / 1000;

endpackage

// File: rtl/masura_perioada_sincronizare_front.sv
// Two-flop synchronizer plus delay flop for a slow asynchronous input.
// Rise and fall strobes share the same latency, so measured durations stay unbiased.
module sincronizare_front (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_semnal,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_semnal;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/masura_perioada.sv
// Period / high-time meter for a slow square wave, counted in clock_in cycles.
// ASTEAPTA | idle, next rise arms a measurement
// MASOARA  | counting; each rise publishes a result, a stall drops back to ASTEAPTA
module masura_perioada
    import masura_perioada_pkg::*;
#(
    parameter int numar_biti     = 20,
    parameter int limita_timeout = 1000000
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  semnal_in,
    output logic [numar_biti-1:0] perioada,
    output logic [numar_biti-1:0] durata_high,
    output logic                  masura_valida,
    output logic                  timeout
);

    localparam logic [numar_biti-1:0] MAXIM  = '1;
    localparam logic [numar_biti-1:0] UNU    = numar_biti'(1);
    localparam logic [numar_biti-1:0] LIMITA = numar_biti'(limita_timeout);

    stare_t                r_stare;
    stare_t                w_stare_urm;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_incarca;
    logic                  w_captura;
    logic                  w_blocaj;
    logic                  r_in_high;
    logic [numar_biti-1:0] r_cnt_per;
    logic [numar_biti-1:0] r_cnt_high;

    sincronizare_front u_sincronizare (
        .i_clk    (clock_in),
        .i_rst    (reset),
        .i_semnal (semnal_in),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_stare <= ASTEAPTA;
        end else begin
            r_stare <= w_stare_urm;
        end
    end

    always_comb begin
        w_stare_urm = r_stare;
        w_incarca   = 1'b0;
        w_captura   = 1'b0;
        w_blocaj    = 1'b0;
        case (r_stare)
            ASTEAPTA: begin
                if (w_rise) begin
                    w_incarca   = 1'b1;
                    w_stare_urm = MASOARA;
                end
            end
            MASOARA: begin
                // a rise in the terminal-count cycle still counts as a measurement
                if (w_rise) begin
                    w_incarca = 1'b1;
                    w_captura = 1'b1;
                end else if (r_cnt_per == LIMITA) begin
                    w_blocaj    = 1'b1;
                    w_stare_urm = ASTEAPTA;
                end
            end
            default: w_stare_urm = ASTEAPTA;
        endcase
    end

    // High phase runs from a rise strobe up to the matching fall strobe.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_in_high <= 1'b0;
        end else if (w_rise) begin
            r_in_high <= 1'b1;
        end else if (w_fall) begin
            r_in_high <= 1'b0;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_cnt_per  <= '0;
            r_cnt_high <= '0;
        end else if (w_incarca) begin
            r_cnt_per  <= UNU;
            r_cnt_high <= UNU;
        end else if (r_stare == MASOARA) begin
            if (r_cnt_per != MAXIM) begin
                r_cnt_per <= r_cnt_per + UNU;
            end
            if (r_in_high && !w_fall && (r_cnt_high != MAXIM)) begin
                r_cnt_high <= r_cnt_high + UNU;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            perioada      <= '0;
            durata_high   <= '0;
            masura_valida <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            masura_valida <= w_captura;
            if (w_captura) begin
                perioada    <= r_cnt_per;
                durata_high <= r_cnt_high;
                timeout     <= 1'b0;
            end else if (w_blocaj) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_masura_perioada.sv
// Bench for masura_perioada: directed and random pulse trains against an input-timeline model.
module tb_masura_perioada;

    localparam int NB  = 20;
    localparam int LIM = 50;
    localparam int LAT = 3;

    logic          clock_in  = 1'b0;
    logic          reset     = 1'b1;
    logic          semnal_in = 1'b0;
    logic [NB-1:0] perioada;
    logic [NB-1:0] durata_high;
    logic          masura_valida;
    logic          timeout;

    masura_perioada #(
        .numar_biti     (NB),
        .limita_timeout (LIM)
    ) dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .semnal_in     (semnal_in),
        .perioada      (perioada),
        .durata_high   (durata_high),
        .masura_valida (masura_valida),
        .timeout       (timeout)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic valid;
        int   per;
        int   high;
        logic tmo;
    } snap_t;

    snap_t q[$];
    snap_t m;
    int    vectors     = 0;
    int    miscompares = 0;
    int    n;
    int    m_last_rise;
    int    m_last_fall;
    logic  m_prev;
    logic  m_armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string ctx);
        chk({ctx, "_perioada"}, 32'(perioada), 0);
        chk({ctx, "_durata_high"}, 32'(durata_high), 0);
        chk({ctx, "_valida"}, {31'b0, masura_valida}, 0);
        chk({ctx, "_timeout"}, {31'b0, timeout}, 0);
    endtask

    // Results are derived from input-timeline events; the meter shows them LAT cycles later.
    task automatic model_reset();
        q.delete();
        m = '{valid: 1'b0, per: 0, high: 0, tmo: 1'b0};
        repeat (LAT) q.push_back(m);
        m_prev      = 1'b0;
        m_armed     = 1'b0;
        m_last_rise = 0;
        m_last_fall = 0;
        n           = 0;
    endtask

    task automatic model_step(input logic v);
        m.valid = 1'b0;
        if (v && !m_prev) begin
            if (m_armed) begin
                m.per   = n - m_last_rise;
                m.high  = m_last_fall - m_last_rise;
                m.valid = 1'b1;
                m.tmo   = 1'b0;
            end
            m_armed     = 1'b1;
            m_last_rise = n;
        end else begin
            if (!v && m_prev) m_last_fall = n;
            if (m_armed && (n - m_last_rise == LIM)) begin
                m.tmo   = 1'b1;
                m_armed = 1'b0;
            end
        end
        m_prev = v;
        n++;
    endtask

    task automatic slot(input logic v);
        snap_t e;
        e = q.pop_front();
        chk("perioada", 32'(perioada), e.per);
        chk("durata_high", 32'(durata_high), e.high);
        chk("masura_valida", {31'b0, masura_valida}, {31'b0, e.valid});
        chk("timeout", {31'b0, timeout}, {31'b0, e.tmo});
        semnal_in = v;
        model_step(v);
        q.push_back(m);
    endtask

    task automatic step(input logic v);
        @(posedge clock_in);
        #1;
        slot(v);
    endtask

    task automatic puls(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic release_reset(input logic v);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        model_reset();
        slot(v);
    endtask

    initial begin
        reset     = 1'b1;
        semnal_in = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        chk_zero("reset_init");
        release_reset(1'b0);

        repeat (6) puls(5, 5);
        repeat (5) puls(4, 3);
        repeat (6) puls(1, 1);

        repeat (3) puls(5, 5);
        repeat (5) puls(2, 2);

        repeat (2) puls(5, 5);
        repeat (70) step(1'b0);
        chk("stall_timeout", {31'b0, timeout}, 1);
        chk("stall_perioada", 32'(perioada), 10);
        chk("stall_durata_high", 32'(durata_high), 5);
        repeat (3) puls(5, 5);

        repeat (3) puls(25, 25);
        chk("limit_perioada", 32'(perioada), 50);
        chk("limit_timeout", {31'b0, timeout}, 0);
        puls(25, 26);
        repeat (3) puls(5, 5);

        repeat (3) step(1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("reset_async");
        repeat (3) @(posedge clock_in);
        release_reset(1'b1);
        repeat (4) step(1'b1);
        repeat (5) step(1'b0);
        repeat (4) puls(5, 5);
        chk("post_reset_perioada", 32'(perioada), 10);
        chk("post_reset_durata_high", 32'(durata_high), 5);

        repeat (40) puls($urandom_range(2, 30), $urandom_range(2, 30));
        repeat (LAT + 2) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
